// File: rtl/instr_seq_unit.sv
// -----------------------------------------------------------------------------
// instr_seq_unit
//   Sequential instruction unit for the TinyALU CPU. Fetches instruction words
//   from an external instruction RAM starting at PC 0. Each word is decoded and
//   dispatched to the memory interface unit (MIU) or the ALU through
//   request/done handshakes. The unit runs until a HALT instruction is executed
//   or the last RAM word has been executed.
//
//   Instruction word layout (IW = OPC_W+ADDR_W+1 bits):
//     [IW-1 : ADDR_W+1]  opcode
//     [ADDR_W : 1]       memory address
//     [0]                register select for LOAD (0 = regA, 1 = regB)
//   Opcodes: 0 NOP, 1 ADD, 2 AND, 3 XOR, 4 MUL, 8 LOAD, 9 STORE, 15 HALT.
//   Every other opcode is executed as a NOP.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   run              start pulse, accepted only in IDLE or HALTED
//   imem_addr/rd     instruction RAM read port (address = pc)
//   imem_data        instruction word, valid one cycle after imem_rd
//   load/store/addr  MIU request. Held until mem_done.
//   result           store data (the result register)
//   mem_done, data   MIU completion. Load data is valid in the same cycle.
//   start/op/A/B     ALU request. Held until alu_done.
//   alu_done         ALU completion. alu_result is valid in the same cycle.
//   busy, done, pc   status: busy outside IDLE/HALTED, done pulses on HALTED entry
//
// Optional build macro
//   IU_PERF_CNT_EN   adds the instr_cnt / stall_cnt outputs. Both are 32-bit
//                    saturating counters, cleared by reset and by an accepted
//                    run.
// -----------------------------------------------------------------------------
module instr_seq_unit #(
  parameter  int DATA_W     = 8,
  parameter  int ADDR_W     = 14,
  parameter  int OPC_W      = 4,
  parameter  int IMEM_DEPTH = 1024,
  localparam int PC_W       = $clog2(IMEM_DEPTH),
  localparam int IW         = OPC_W + ADDR_W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  output logic [PC_W-1:0]     imem_addr,
  output logic                imem_rd,
  input  logic [IW-1:0]       imem_data,
  output logic                load,
  output logic                store,
  output logic [ADDR_W-1:0]   addr,
  output logic [2*DATA_W-1:0] result,
  input  logic                mem_done,
  input  logic [DATA_W-1:0]   data,
  output logic                start,
  output logic [OPC_W-1:0]    op,
  output logic [DATA_W-1:0]   A,
  output logic [DATA_W-1:0]   B,
  input  logic                alu_done,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                busy,
  output logic                done,
`ifdef IU_PERF_CNT_EN
  output logic [31:0]         instr_cnt,
  output logic [31:0]         stall_cnt,
`endif
  output logic [PC_W-1:0]     pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_WAIT,
    S_ALU_WAIT,
    S_HALTED
  } state_t;

  localparam logic [OPC_W-1:0] OPC_ADD   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OPC_AND   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OPC_XOR   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_MUL   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OPC_LOAD  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OPC_STORE = OPC_W'(9);
  localparam logic [OPC_W-1:0] OPC_HALT  = OPC_W'(15);

  localparam logic [PC_W-1:0]  PC_LAST   = PC_W'(IMEM_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t               state_q;
  logic [PC_W-1:0]      pc_q;
  logic [PC_W-1:0]      pc_d;
  logic                 imem_rd_q;
  logic                 load_q;
  logic                 store_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 ld_sel_q;   // destination of the pending LOAD
  logic [2*DATA_W-1:0]  result_q;
  logic                 start_q;
  logic [OPC_W-1:0]     op_q;
  logic [DATA_W-1:0]    a_q;
  logic [DATA_W-1:0]    b_q;
  logic [DATA_W-1:0]    rega_q;
  logic [DATA_W-1:0]    regb_q;
  logic                 busy_q;
  logic                 done_q;

  // ---------------------------------------------------------------------------
  // Decode of the instruction word. imem_data is only consumed in DECODE.
  // ---------------------------------------------------------------------------
  logic [OPC_W-1:0]  dec_opc;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_sel;
  logic              dec_is_load;
  logic              dec_is_store;
  logic              dec_is_alu;
  logic              dec_is_halt;

  assign dec_opc      = imem_data[IW-1 -: OPC_W];
  assign dec_addr     = imem_data[ADDR_W:1];
  assign dec_sel      = imem_data[0];
  assign dec_is_load  = (dec_opc == OPC_LOAD);
  assign dec_is_store = (dec_opc == OPC_STORE);
  assign dec_is_halt  = (dec_opc == OPC_HALT);
  assign dec_is_alu   = (dec_opc == OPC_ADD) || (dec_opc == OPC_AND) ||
                        (dec_opc == OPC_XOR) || (dec_opc == OPC_MUL);

  logic run_ok;
  assign run_ok = run && ((state_q == S_IDLE) || (state_q == S_HALTED));

  // adv: the current instruction finishes this cycle and execution moves on
  // to the next PC. This is either the next word or HALTED at the end of
  // memory. HALT does not raise adv because it never moves the PC.
  logic adv;
  always_comb begin
    adv = 1'b0;
    unique case (state_q)
      S_DECODE:   adv = !dec_is_load && !dec_is_store && !dec_is_alu && !dec_is_halt;
      S_MEM_WAIT: adv = mem_done;
      S_ALU_WAIT: adv = alu_done;
      default:    adv = 1'b0;
    endcase
  end

  logic at_last;
  assign at_last = (pc_q == PC_LAST);
  assign pc_d    = pc_q + PC_W'(1);

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      imem_rd_q <= 1'b0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      addr_q    <= '0;
      ld_sel_q  <= 1'b0;
      result_q  <= '0;
      start_q   <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rega_q    <= '0;
      regb_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // imem_rd and done are single-cycle strobes.
      imem_rd_q <= 1'b0;
      done_q    <= 1'b0;

      unique case (state_q)
        S_IDLE, S_HALTED: begin
          if (run_ok) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            imem_rd_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end

        S_FETCH: state_q <= S_DECODE;

        S_DECODE: begin
          if (dec_is_load || dec_is_store) begin
            load_q   <= dec_is_load;
            store_q  <= dec_is_store;
            addr_q   <= dec_addr;
            ld_sel_q <= dec_sel;
            state_q  <= S_MEM_WAIT;
          end else if (dec_is_alu) begin
            op_q    <= dec_opc;
            a_q     <= rega_q;
            b_q     <= regb_q;
            start_q <= 1'b1;
            state_q <= S_ALU_WAIT;
          end else if (dec_is_halt) begin
            state_q <= S_HALTED;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        S_MEM_WAIT: begin
          if (mem_done) begin
            load_q  <= 1'b0;
            store_q <= 1'b0;
            if (load_q) begin
              if (ld_sel_q) regb_q <= data;
              else          rega_q <= data;
            end
          end
        end

        S_ALU_WAIT: begin
          if (alu_done) begin
            start_q  <= 1'b0;
            result_q <= alu_result;
          end
        end

        default: state_q <= S_IDLE;
      endcase

      // Common advance path. It runs after the case, so its state update
      // takes priority over the case branches above. The PC does not wrap:
      // executing the last word ends the program.
      if (adv) begin
        if (at_last) begin
          state_q <= S_HALTED;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end else begin
          pc_q      <= pc_d;
          state_q   <= S_FETCH;
          imem_rd_q <= 1'b1;
        end
      end
    end
  end

  assign imem_addr = pc_q;
  assign imem_rd   = imem_rd_q;
  assign load      = load_q;
  assign store     = store_q;
  assign addr      = addr_q;
  assign result    = result_q;
  assign start     = start_q;
  assign op        = op_q;
  assign A         = a_q;
  assign B         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pc        = pc_q;

`ifdef IU_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters. HALT counts as a retired instruction. Every cycle
  // spent waiting on the MIU or the ALU counts as a stall.
  // ---------------------------------------------------------------------------
  logic        retire;
  logic [31:0] instr_cnt_q;
  logic [31:0] stall_cnt_q;

  assign retire = adv || ((state_q == S_DECODE) && dec_is_halt);

  always_ff @(posedge clk) begin
    if (reset || run_ok) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (retire && (instr_cnt_q != '1))
        instr_cnt_q <= instr_cnt_q + 32'd1;
      if (((state_q == S_MEM_WAIT) || (state_q == S_ALU_WAIT)) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_seq_unit.sv
// Directed and randomized bench for instr_seq_unit. The bench models the
// instruction RAM, the MIU and the ALU. An instruction-level reference model
// predicts the fetch trace, the MIU/ALU requests, the final PC and the
// counter values for each program.
module tb_instr_seq_unit;
  localparam int DEPTH = 16;
  localparam int PC_W  = 4;
  localparam int IW    = 19;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [PC_W-1:0] imem_addr;
  logic        imem_rd;
  logic [IW-1:0] imem_data;
  logic        load, store;
  logic [13:0] addr;
  logic [15:0] result;
  logic        mem_done;
  logic [7:0]  data;
  logic        start;
  logic [3:0]  op;
  logic [7:0]  A, B;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        busy, done;
  logic [PC_W-1:0] pc;
`ifdef IU_PERF_CNT_EN
  logic [31:0] instr_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_seq_unit #(.DATA_W(8), .ADDR_W(14), .OPC_W(4), .IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .load(load), .store(store), .addr(addr), .result(result),
    .mem_done(mem_done), .data(data),
    .start(start), .op(op), .A(A), .B(B),
    .alu_done(alu_done), .alu_result(alu_result),
    .busy(busy), .done(done),
`ifdef IU_PERF_CNT_EN
    .instr_cnt(instr_cnt), .stall_cnt(stall_cnt),
`endif
    .pc(pc)
  );

  int ncmp = 0, nerr = 0;

  logic [IW-1:0] imem [DEPTH];
  logic [7:0]    dmem [256];

  // environment configuration and observations
  int mem_delay = 0, alu_delay = 0;
  bit spur_en = 0;
  int done_cnt = 0, stab_err = 0, post_err = 0, excl_err = 0, spur_cnt = 0;
  int last_mem_hi = 0, last_alu_hi = 0;
  logic [15:0] last_st_res;
  logic [19:0] last_alu;
  int          got_fetch[$], exp_fetch[$];
  logic [30:0] got_mem[$],   exp_mem[$];
  logic [19:0] got_alu[$],   exp_alu[$];

  // reference model state
  logic [7:0]  mA = 0, mB = 0;
  logic [15:0] mR = 0;
  int exp_pc, exp_ret, exp_nmem, exp_nalu;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] ins(int opc, int a, int sel);
    logic [3:0] o; logic [13:0] ad; logic s;
    o = 4'(opc); ad = 14'(a); s = 1'(sel);
    return {o, ad, s};
  endfunction

  function automatic logic [15:0] alu_fn(logic [3:0] o, logic [7:0] a, logic [7:0] b);
    case (o)
      4'd1:    return 16'(a) + 16'(b);
      4'd2:    return {8'h00, a & b};
      4'd3:    return {8'h00, a ^ b};
      default: return 16'(a) * 16'(b);
    endcase
  endfunction

  // Instruction-level reference: walk the program from PC 0.
  task automatic model_run();
    int p; int o; logic [IW-1:0] w; logic [13:0] a; logic s;
    exp_fetch.delete(); exp_mem.delete(); exp_alu.delete();
    exp_ret = 0; exp_nmem = 0; exp_nalu = 0; p = 0;
    forever begin
      exp_fetch.push_back(p);
      w = imem[p]; o = int'(w[18:15]); a = w[14:1]; s = w[0];
      exp_ret++;
      if (o == 15) break;
      if (o == 8) begin
        if (s) mB = dmem[a[7:0]]; else mA = dmem[a[7:0]];
        exp_mem.push_back({1'b1, a, 16'h0000}); exp_nmem++;
      end else if (o == 9) begin
        exp_mem.push_back({1'b0, a, mR}); exp_nmem++;
      end else if (o >= 1 && o <= 4) begin
        exp_alu.push_back({4'(o), mA, mB});
        mR = alu_fn(4'(o), mA, mB); exp_nalu++;
      end
      if (p == DEPTH - 1) break;
      p++;
    end
    exp_pc = p;
  endtask

  // instruction RAM: one-cycle read latency
  initial begin
    imem_data = '0;
    forever begin
      @(posedge clk);
      if (imem_rd) imem_data <= imem[imem_addr];
    end
  end

  // MIU responder: mem_done after mem_delay extra cycles, checks request stability
  logic mk; logic [13:0] ma; logic [15:0] mr; bit mab; int mhi;
  initial begin
    mem_done = 1'b0; data = '0;
    forever begin
      @(negedge clk);
      if (!reset && (load || store)) begin
        mk = load; ma = addr; mr = load ? 16'h0 : result; mab = 0; mhi = 1;
        got_mem.push_back({mk, ma, mr});
        if (!mk) last_st_res = result;
        for (int i = 0; i < mem_delay; i++) begin
          @(negedge clk);
          if (reset) begin mab = 1; break; end
          if (load !== mk || store !== ~mk || addr !== ma || busy !== 1'b1) stab_err++;
          mhi++;
        end
        if (!mab) begin
          data = dmem[ma[7:0]]; mem_done = 1'b1; last_mem_hi = mhi;
          @(negedge clk);
          mem_done = 1'b0; data = '0;
          if (load !== 1'b0 || store !== 1'b0) post_err++;
        end
      end
    end
  end

  // ALU responder, optionally emits spurious alu_done while the MIU is busy
  logic [3:0] ao; logic [7:0] aa, abv; bit aab; int ahi;
  initial begin
    alu_done = 1'b0; alu_result = '0;
    forever begin
      @(negedge clk);
      if (!reset && start) begin
        ao = op; aa = A; abv = B; aab = 0; ahi = 1;
        got_alu.push_back({ao, aa, abv}); last_alu = {ao, aa, abv};
        for (int i = 0; i < alu_delay; i++) begin
          @(negedge clk);
          if (reset) begin aab = 1; break; end
          if (start !== 1'b1 || op !== ao || A !== aa || B !== abv || busy !== 1'b1) stab_err++;
          ahi++;
        end
        if (!aab) begin
          alu_result = alu_fn(ao, aa, abv); alu_done = 1'b1; last_alu_hi = ahi;
          @(negedge clk);
          alu_done = 1'b0;
          if (start !== 1'b0) post_err++;
        end
      end else if (!reset && spur_en && (load || store)) begin
        alu_result = 16'hDEAD; alu_done = 1'b1; spur_cnt++;
        @(negedge clk);
        alu_done = 1'b0;
      end
    end
  end

  // monitor
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (done) done_cnt++;
      if (imem_rd) got_fetch.push_back(int'(imem_addr));
      if (int'(load) + int'(store) + int'(start) > 1) excl_err++;
    end
  end

  task automatic go(int rerun_at);
    int n;
    got_fetch.delete(); got_mem.delete(); got_alu.delete(); done_cnt = 0;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk); n++;
      run = (n == rerun_at) ? 1'b1 : 1'b0;
    end
    run = 1'b0;
    chk("done_timeout", 32'(done_cnt != 0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_run(string tag);
    int mis;
    chk({tag, "_fetch_n"}, got_fetch.size(), exp_fetch.size());
    mis = 0;
    foreach (exp_fetch[i]) if (i >= got_fetch.size() || got_fetch[i] != exp_fetch[i]) mis++;
    chk({tag, "_fetch_seq"}, mis, 0);
    chk({tag, "_mem_n"}, got_mem.size(), exp_mem.size());
    mis = 0;
    foreach (exp_mem[i]) if (i >= got_mem.size() || got_mem[i] !== exp_mem[i]) mis++;
    chk({tag, "_mem_seq"}, mis, 0);
    chk({tag, "_alu_n"}, got_alu.size(), exp_alu.size());
    mis = 0;
    foreach (exp_alu[i]) if (i >= got_alu.size() || got_alu[i] !== exp_alu[i]) mis++;
    chk({tag, "_alu_seq"}, mis, 0);
    chk({tag, "_pc"}, 32'(pc), exp_pc);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_stable"}, stab_err, 0);
    chk({tag, "_release"}, post_err, 0);
    chk({tag, "_excl"}, excl_err, 0);
`ifdef IU_PERF_CNT_EN
    chk({tag, "_instr_cnt"}, instr_cnt, exp_ret);
    chk({tag, "_stall_cnt"}, stall_cnt, exp_nmem * (mem_delay + 1) + exp_nalu * (alu_delay + 1));
`endif
  endtask

  task automatic fill(logic [IW-1:0] w);
    for (int i = 0; i < DEPTH; i++) imem[i] = w;
  endtask

  initial begin
    int n;
    int pool[9] = '{0, 1, 2, 3, 4, 8, 9, 5, 12};
    reset = 1'b1; run = 1'b0;
    for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom);
    fill(ins(15, 0, 0));
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_strobes", {28'd0, load, store, start, imem_rd}, 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_alu_if", {12'd0, op, A, B}, 0);
`ifdef IU_PERF_CNT_EN
    chk("rst_cnts", instr_cnt | stall_cnt, 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // LOAD A, LOAD B, ADD, STORE, HALT
    dmem[8'h10] = 8'h05; dmem[8'h11] = 8'h07;
    imem[0] = ins(8, 'h10, 0); imem[1] = ins(8, 'h11, 1); imem[2] = ins(1, 0, 0);
    imem[3] = ins(9, 'h12, 0); imem[4] = ins(15, 0, 0);
    mem_delay = 1; alu_delay = 2;
    model_run(); go(-1); check_run("p1");
    chk("p1_alu_ops", 32'(last_alu), {12'd0, 4'd1, 8'h05, 8'h07});
    chk("p1_store", {16'd0, last_st_res}, 32'h000C);
    chk("p1_pc4", 32'(pc), 4);

    // MUL 0xFF*0xFF with 5-cycle ALU delay
    dmem[8'h20] = 8'hFF; dmem[8'h21] = 8'hFF;
    fill(ins(15, 0, 0));
    imem[0] = ins(8, 'h20, 0); imem[1] = ins(8, 'h21, 1); imem[2] = ins(4, 0, 0);
    imem[3] = ins(9, 'h22, 0);
    mem_delay = 0; alu_delay = 5;
    model_run(); go(-1); check_run("mul");
    chk("mul_store", {16'd0, last_st_res}, 32'hFE01);
    chk("mul_start_cycles", last_alu_hi, 6);

    // LOAD with 10-cycle mem delay
    fill(ins(15, 0, 0));
    imem[0] = ins(8, 'h30, 1);
    mem_delay = 10; alu_delay = 0;
    model_run(); go(-1); check_run("ldw");
    chk("ldw_load_cycles", last_mem_hi, 11);

    // all NOP, no HALT: runs off the end
    fill(ins(0, 0, 0));
    mem_delay = 0;
    model_run(); go(-1); check_run("nop");
    chk("nop_fetches", got_fetch.size(), 16);
    chk("nop_pc15", 32'(pc), 15);

    // reset during ALU_WAIT
    fill(ins(15, 0, 0));
    imem[0] = ins(8, 'h20, 0); imem[1] = ins(4, 0, 0);
    alu_delay = 50;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    n = 0;
    while (start !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("rst_mid_reach_alu", 32'(start), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_start", 32'(start), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_pc", 32'(pc), 0);
    @(negedge clk);
    reset = 1'b0; alu_delay = 0;
    mA = 0; mB = 0; mR = 0;
    repeat (2) @(negedge clk);
    imem[0] = ins(9, 'h40, 0); imem[1] = ins(15, 0, 0);
    model_run(); go(-1); check_run("restart");
    chk("restart_store0", {16'd0, last_st_res}, 0);

    // spurious alu_done in MEM_WAIT plus run while busy
    dmem[8'h10] = 8'h33; dmem[8'h11] = 8'h0F;
    fill(ins(15, 0, 0));
    imem[0] = ins(8, 'h10, 0); imem[1] = ins(8, 'h11, 1); imem[2] = ins(3, 0, 0);
    imem[3] = ins(9, 'h12, 0);
    mem_delay = 3; alu_delay = 1; spur_en = 1; spur_cnt = 0;
    model_run(); go(4); check_run("spur");
    chk("spur_seen", 32'(spur_cnt != 0), 1);
    chk("spur_store", {16'd0, last_st_res}, 32'h003C);
    spur_en = 0;

    // randomized programs
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++)
        imem[i] = ($urandom_range(0, 19) == 0) ? ins(15, 0, 0)
                : ins(pool[$urandom_range(0, 8)], int'($urandom_range(0, 16383)), int'($urandom_range(0, 1)));
      mem_delay = int'($urandom_range(0, 3)); alu_delay = int'($urandom_range(0, 3));
      model_run(); go(-1); check_run($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/instr_seq_unit.md
Name: instr_seq_unit

Overview:
Parametrised successor to the single-instruction IU for the TinyALU CPU. Fetches instructions sequentially from an external instruction RAM, decodes them, and drives the memory interface unit (MIU) and the ALU through proper request/done handshakes. Holds operand registers A/B and a result register. Runs a program from PC 0 until HALT or end of memory.

Parameters:
DATA_W, 8, operand width; ALU result is 2*DATA_W.
ADDR_W, 14, main-memory address width.
OPC_W, 4, opcode field width.
IMEM_DEPTH, 1024, instruction RAM depth in words; PC width = $clog2(IMEM_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  one-cycle pulse; starts execution at PC 0 from IDLE or HALTED, ignored otherwise.
- imem_addr  out  PC_W  instruction RAM read address.
- imem_rd  out  1  instruction RAM read strobe.
- imem_data  in  OPC_W+ADDR_W+1  instruction word, valid 1 cycle after imem_rd.
- load  out  1  MIU load request.
- store  out  1  MIU store request.
- addr  out  ADDR_W  MIU address.
- result  out  2*DATA_W  store data to MIU.
- mem_done  in  1  MIU completion; load data valid same cycle.
- data  in  DATA_W  MIU load data.
- start  out  1  ALU start.
- op  out  OPC_W  ALU opcode.
- A, B  out  DATA_W each  ALU operands.
- alu_done  in  1  ALU completion; alu_result valid same cycle.
- alu_result  in  2*DATA_W  ALU result.
- busy  out  1  high in any state except IDLE/HALTED.
- done  out  1  one-cycle pulse on entry to HALTED.
- pc  out  PC_W  current PC.

Behaviour:
- Instruction word: [OPC_W+ADDR_W : ADDR_W+1] opcode, [ADDR_W:1] address, [0] reg select (0=A, 1=B).
- Opcodes: 0 NOP, 1 ADD, 2 AND, 3 XOR, 4 MUL (to ALU), 8 LOAD, 9 STORE, 15 HALT; any other value is executed as NOP.
- Reset: state IDLE. pc, regA, regB, result, addr, op, A, B all 0. load, store, start, imem_rd, busy, done all 0.
- FSM states: IDLE, FETCH, DECODE, MEM_WAIT, ALU_WAIT, HALTED.
  - IDLE/HALTED --run--> FETCH, with pc=0.
  - FETCH: imem_rd=1 and imem_addr=pc for exactly 1 cycle, then DECODE.
  - DECODE registers imem_data and dispatches.
    - LOAD: load=1, addr=field, then MEM_WAIT.
    - STORE: store=1, addr=field, result=result reg, then MEM_WAIT.
    - ALU op: op=opcode, A=regA, B=regB, start=1, then ALU_WAIT.
    - NOP: advance.
    - HALT: HALTED, done pulse.
  - MEM_WAIT: load/store and addr held stable until mem_done. On mem_done: deassert next cycle; for LOAD, write data into regA or regB per the select bit; advance.
  - ALU_WAIT: start, op, A, B held stable until alu_done. On alu_done: start=0 next cycle, result reg <= alu_result, advance.
- Advance: if pc==IMEM_DEPTH-1, go to HALTED with done pulse. Else pc+1 and go to FETCH. No wrap.
- Minimum latency per instruction: NOP 2 cycles; LOAD/STORE/ALU 3 cycles plus the wait for the done input.
- mem_done or alu_done received outside its wait state is ignored.
- load, store and start are mutually exclusive; at most one is high at any time.
- STORE with no prior ALU op stores 0.
- Reset mid-operation: all outputs take reset values on the next edge regardless of state. Pending handshakes are abandoned.
- run asserted while busy is ignored.

Optional Feature:
IU_PERF_CNT_EN:
- Defined: adds outputs instr_cnt[31:0] (increments on each retired instruction, HALT included) and stall_cnt[31:0] (increments each cycle in MEM_WAIT or ALU_WAIT). Both clear on reset and on an accepted run, and saturate at all-ones.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Program LOAD 0x10→A, LOAD 0x11→B, ADD, STORE 0x12, HALT; MIU returns 0x05/0x07 → A=0x05, B=0x07, store asserted with addr=0x12 and result=0x000C, done pulses once, pc=4.
- MUL with regA=0xFF, regB=0xFF → result=0xFE01 stored; start held high through a 5-cycle alu_done delay and low the cycle after alu_done.
- mem_done delayed 10 cycles on LOAD → load and addr stable for all 10 cycles, load low on the next cycle, busy high throughout.
- RAM filled with NOP, no HALT, IMEM_DEPTH=16 → HALTED after pc=15, done pulses, imem_addr never returns to 0.
- reset asserted during ALU_WAIT → next cycle start=0, state IDLE, pc=0; a later run restarts cleanly from pc 0.
- Spurious alu_done during MEM_WAIT and run asserted while busy → both ignored, program completes normally. With IU_PERF_CNT_EN defined, instr_cnt equals the instruction count.
